// File: rtl/mdu_seq_32_if.sv
// Operation types plus the execute-stage <-> multiply/divide sequencer bundle.
// Latency: none; this file holds only declarations.
// Backpressure: o_stall holds the pipeline. There is no result backpressure.
// Ports (master = execute stage, slave = sequencer):
//   i_valid/i_alu_op/i_a/i_b/i_dest/i_flush : instruction in execute
//   o_ready/o_stall/o_valid/o_result/o_dest/o_div_by_zero : sequencer status/result
package mdu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_MUL, ALU_DIV
  } alu_op_e;
endpackage

interface mdu_seq_32_if #(
  parameter int WIDTH      = 32,
  parameter int REG_SELECT = 5
);
  import mdu_pkg::*;

  logic                  i_valid;
  alu_op_e               i_alu_op;
  logic [WIDTH-1:0]      i_a;
  logic [WIDTH-1:0]      i_b;
  logic [REG_SELECT-1:0] i_dest;
  logic                  i_flush;
  logic                  o_ready;
  logic                  o_stall;
  logic                  o_valid;
  logic [WIDTH-1:0]      o_result;
  logic [REG_SELECT-1:0] o_dest;
  logic                  o_div_by_zero;

  modport master (
    output i_valid, i_alu_op, i_a, i_b, i_dest, i_flush,
    input  o_ready, o_stall, o_valid, o_result, o_dest, o_div_by_zero
  );

  modport slave (
    input  i_valid, i_alu_op, i_a, i_b, i_dest, i_flush,
    output o_ready, o_stall, o_valid, o_result, o_dest, o_div_by_zero
  );
endinterface

// File: rtl/mdu_seq_32.sv
// Iterative shift-add multiplier / signed restoring divider for the execute stage.
// Latency: result valid WIDTH edges after the accept edge; divide-by-zero completes on the edge after accept.
// Backpressure: o_stall holds the pipeline while busy. The result is a one-cycle pulse with no backpressure.
// Ports: clk, rst_n (async active-low), bus (mdu_seq_32_if.slave): instruction in, result/status out.
module mdu_seq_32
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mdu_seq_32_if.slave   bus
);
  localparam int REG_SELECT = $clog2(NUM_REG);
  localparam int CNT_W      = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH-1:0]      op_a;     // multiplicand (MUL) / dividend shifting into quotient (DIV)
  logic [WIDTH-1:0]      op_b;     // multiplier (MUL) / divisor magnitude (DIV)
  logic [WIDTH:0]        acc;      // product accumulator / partial remainder
  logic                  neg_q;
  logic [REG_SELECT-1:0] dest_q;

  logic                  is_md, is_div, accept, last, b_zero;
  logic [WIDTH-1:0]      a_mag, b_mag;
  logic [WIDTH-1:0]      mul_sum;
  logic [WIDTH:0]        div_sh, div_diff, rem_nxt;
  logic                  div_ge;
  logic [WIDTH-1:0]      q_nxt;

  assign is_md  = (bus.i_alu_op == ALU_MUL) || (bus.i_alu_op == ALU_DIV);
  assign is_div = (bus.i_alu_op == ALU_DIV);
  assign b_zero = (bus.i_b == '0);
  assign accept = bus.i_valid & is_md & bus.o_ready & ~bus.i_flush;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  assign bus.o_ready = (state == S_IDLE);
  assign bus.o_valid = (state == S_DONE) & ~bus.i_flush;
  assign bus.o_stall = bus.i_valid & is_md & ~bus.o_valid;

  // Magnitudes of the most negative value wrap to itself, which is the
  // correct unsigned magnitude, so 0x80000000 / -1 yields 0x80000000.
  assign a_mag = bus.i_a[WIDTH-1] ? -bus.i_a : bus.i_a;
  assign b_mag = bus.i_b[WIDTH-1] ? -bus.i_b : bus.i_b;

  // Multiply step: only the low WIDTH bits are kept, so no sign handling is needed.
  assign mul_sum = acc[WIDTH-1:0] + (op_b[0] ? op_a : '0);

  // Restoring divide step. The remainder stays below the divisor, so the shifted
  // value never sets bit WIDTH; a set bit WIDTH in the difference means a borrow.
  assign div_sh   = {acc[WIDTH-1:0], op_a[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, op_b};
  assign div_ge   = ~div_diff[WIDTH];
  assign rem_nxt  = div_ge ? div_diff : div_sh;
  assign q_nxt    = {op_a[WIDTH-2:0], div_ge};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_div)     state_nxt = S_MUL;
          else if (b_zero) state_nxt = S_DONE;
          else             state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: if (last) state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
    if (bus.i_flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cnt               <= '0;
      op_a              <= '0;
      op_b              <= '0;
      acc               <= '0;
      neg_q             <= 1'b0;
      dest_q            <= '0;
      bus.o_result      <= '0;
      bus.o_dest        <= '0;
      bus.o_div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            dest_q <= bus.i_dest;
            neg_q  <= bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1];
            op_a   <= is_div ? a_mag : bus.i_a;
            op_b   <= is_div ? b_mag : bus.i_b;
            if (is_div && b_zero) begin
              bus.o_result      <= '1;
              bus.o_dest        <= bus.i_dest;
              bus.o_div_by_zero <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (!bus.i_flush) begin
            acc  <= {1'b0, mul_sum};
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
            cnt  <= cnt + 1'b1;
            if (last) begin
              bus.o_result      <= mul_sum;
              bus.o_dest        <= dest_q;
              bus.o_div_by_zero <= 1'b0;
            end
          end
        end
        S_DIV: begin
          if (!bus.i_flush) begin
            acc  <= rem_nxt;
            op_a <= q_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
              bus.o_result      <= neg_q ? -q_nxt : q_nxt;
              bus.o_dest        <= dest_q;
              bus.o_div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
